// File: rtl/av_master_arbiter_if.sv
// Bundle of every signal between the two-requester Avalon-MM arbiter and its
// surroundings.
//   r0_* / r1_*  : requester side. req/write/addr/wdata in; ack/err/rdata out.
//   av_*         : shared 16-bit Avalon-MM master port towards the slave.
//   busy, grant  : arbiter status.
// Modports:
//   master : the arbiter's view (drives av_* commands and requester responses).
//   slave  : the environment's view (requesters plus the Avalon slave).
interface av_master_arbiter_if;
  logic        r0_req;
  logic        r1_req;
  logic        r0_write;
  logic        r1_write;
  logic [15:0] r0_addr;
  logic [15:0] r1_addr;
  logic [15:0] r0_wdata;
  logic [15:0] r1_wdata;
  logic        r0_ack;
  logic        r1_ack;
  logic        r0_err;
  logic        r1_err;
  logic [15:0] r0_rdata;
  logic [15:0] r1_rdata;
  logic [15:0] av_address;
  logic [15:0] av_writedata;
  logic        av_write;
  logic        av_read;
  logic [15:0] av_readdata;
  logic        av_waitrequest;
  logic        busy;
  logic        grant;

  modport master (
    input  r0_req, r1_req, r0_write, r1_write,
    input  r0_addr, r1_addr, r0_wdata, r1_wdata,
    output r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata,
    output av_address, av_writedata, av_write, av_read,
    input  av_readdata, av_waitrequest,
    output busy, grant
  );

  modport slave (
    output r0_req, r1_req, r0_write, r1_write,
    output r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  r0_ack, r1_ack, r0_err, r1_err, r0_rdata, r1_rdata,
    input  av_address, av_writedata, av_write, av_read,
    output av_readdata, av_waitrequest,
    input  busy, grant
  );
endinterface

// File: rtl/av_master_arbiter.sv
// Two-requester arbiter for a single 16-bit Avalon-MM master port.
// r0 (CPU register interface) and r1 (debug/DMA port) each hold a level
// request; the winner's command is registered and held on the Avalon port
// until the slave drops waitrequest, or until a programmable stall timeout
// aborts it with an error so a hung slave cannot lock up a requester.
// Ports:
//   sysclk      : system clock, rising edge.
//   sysreset_n  : asynchronous active-low reset.
//   bus         : av_master_arbiter_if.master (requesters, Avalon port, status).
// Parameters:
//   FIXED_PRIO     : 1 = r0 wins simultaneous requests, 0 = round-robin.
//   TIMEOUT_CYCLES : stall cycles before abort, 0 disables the timeout.
//   ERR_RDATA      : read data returned for an aborted read.
module av_master_arbiter #(
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [15:0] ERR_RDATA      = 16'hDEAD
) (
  input logic                 sysclk,
  input logic                 sysreset_n,
  av_master_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic        pick;
  logic        expire;
  logic [15:0] capture;

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;  // r0 wins the first round-robin tie
      grant_q  <= 1'b0;
      busy_q   <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      cnt_q    <= 16'd0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      write_q  <= write_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    write_d  = write_q;
    read_d   = read_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    // Requester chosen if the arbiter is idle: a lone request wins outright,
    // a tie goes to r0 (fixed) or to whoever did not own the last transfer.
    if (bus.r0_req && bus.r1_req) pick = FIXED_PRIO ? 1'b0 : ~last_q;
    else                          pick = bus.r1_req;

    // Abort point: the counter has seen TIMEOUT_CYCLES-1 stalled edges, so
    // a stall on this edge is the last one tolerated.
    expire  = (TIMEOUT_CYCLES != 16'd0) && (cnt_q == TIMEOUT_CYCLES - 16'd1);
    // Acceptance wins over expiry on the same edge, so waitrequest alone
    // decides between real data and the error value.
    capture = bus.av_waitrequest ? ERR_RDATA : bus.av_readdata;

    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          addr_d  = pick ? bus.r1_addr  : bus.r0_addr;
          wdata_d = pick ? bus.r1_wdata : bus.r0_wdata;
          write_d = pick ? bus.r1_write : bus.r0_write;
          read_d  = ~write_d;
          grant_d = pick;
          last_d  = pick;
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.av_waitrequest || expire) begin
          write_d          = 1'b0;
          read_d           = 1'b0;
          busy_d           = 1'b0;
          ack_d[grant_q]   = 1'b1;
          err_d[grant_q]   = bus.av_waitrequest;
          if (read_q) begin
            if (grant_q) rdata1_d = capture;
            else         rdata0_d = capture;
          end
          state_d = DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        ack_d   = 2'b00;
        err_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.av_address   = addr_q;
  assign bus.av_writedata = wdata_q;
  assign bus.av_write     = write_q;
  assign bus.av_read      = read_q;
  assign bus.busy         = busy_q;
  assign bus.grant        = grant_q;
  assign bus.r0_ack       = ack_q[0];
  assign bus.r1_ack       = ack_q[1];
  assign bus.r0_err       = err_q[0];
  assign bus.r1_err       = err_q[1];
  assign bus.r0_rdata     = rdata0_q;
  assign bus.r1_rdata     = rdata1_q;

endmodule

// File: tb/tb_av_master_arbiter.sv
`timescale 1ns/1ps
module tb_av_master_arbiter;
  localparam int          TMO  = 8;
  localparam logic [15:0] ERRV = 16'hDEAD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  av_master_arbiter_if ifa ();
  av_master_arbiter_if ifb ();

  av_master_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(16'd8), .ERR_RDATA(16'hDEAD)) dut_rr (
    .sysclk(clk), .sysreset_n(rst_n), .bus(ifa));
  av_master_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(16'd0), .ERR_RDATA(16'hDEAD)) dut_fp (
    .sysclk(clk), .sysreset_n(rst_n), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Expected completion of one transfer on dut_rr.
  typedef struct {
    int          cyc;
    bit          who;
    logic [15:0] rdata;
    bit          err;
  } exp_t;
  exp_t sbq[$];

  // Transaction-level reference state for dut_rr.
  int          cyc = 0;
  bit          m_act = 0, m_last = 1, m_own = 0, m_gnt = 0, m_wr = 0, m_err = 0;
  logic [15:0] m_addr = 0, m_wdata = 0, m_data = 0, m_rd0 = 0, m_rd1 = 0;
  int          m_g = 0, m_a = 0, m_w = 0;
  int          force_w = -1;
  int          force_d = -1;

  // Reference model and Avalon slave: at each grant it picks the winner by
  // the arbitration rules, chooses the slave's wait-state count, predicts the
  // completion edge (W+1 edges, or TMO edges when W >= TMO) and the outcome.
  initial begin : model
    exp_t e;
    ifa.av_waitrequest = 1'b1;
    ifa.av_readdata    = 16'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_act = 0; m_last = 1; m_gnt = 0; m_rd0 = 0; m_rd1 = 0;
        sbq.delete();
      end else begin
        cyc++;
        if (m_act) begin
          if (cyc == m_a + 1) m_act = 0;
        end else if (ifa.r0_req || ifa.r1_req) begin
          m_own   = (ifa.r0_req && ifa.r1_req) ? !m_last : ifa.r1_req;
          m_last  = m_own;
          m_gnt   = m_own;
          m_act   = 1;
          m_g     = cyc;
          m_wr    = m_own ? ifa.r1_write : ifa.r0_write;
          m_addr  = m_own ? ifa.r1_addr  : ifa.r0_addr;
          m_wdata = m_own ? ifa.r1_wdata : ifa.r0_wdata;
          m_w     = (force_w >= 0) ? force_w : int'($urandom_range(0, 10));
          m_data  = (force_d >= 0) ? 16'(force_d) : 16'($urandom);
          m_err   = (m_w >= TMO);
          m_a     = m_g + (m_err ? TMO : m_w + 1);
          if (!m_wr) begin
            if (m_own) m_rd1 = m_err ? ERRV : m_data;
            else       m_rd0 = m_err ? ERRV : m_data;
          end
          e.cyc   = m_a;
          e.who   = m_own;
          e.rdata = m_own ? m_rd1 : m_rd0;
          e.err   = m_err;
          sbq.push_back(e);
        end
        #1;
        if (m_act && cyc < m_a) begin
          ifa.av_waitrequest = ((cyc + 1 - m_g) <= m_w);
          ifa.av_readdata    = ((cyc + 1 - m_g) == m_w + 1) ? m_data : 16'($urandom);
        end else begin
          ifa.av_waitrequest = 1'($urandom_range(0, 1));
          ifa.av_readdata    = 16'($urandom);
        end
      end
    end
  end

  // Monitor: per-cycle command checks plus scoreboard pops on every ack.
  initial begin : monitor
    exp_t e;
    bit   cmd;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cmd = m_act && (cyc < m_a);
        chk("av_write", 32'(ifa.av_write), 32'(cmd && m_wr));
        chk("av_read", 32'(ifa.av_read), 32'(cmd && !m_wr));
        chk("busy", 32'(ifa.busy), 32'(cmd));
        chk("grant", 32'(ifa.grant), 32'(m_gnt));
        if (cmd) begin
          chk("av_address", 32'(ifa.av_address), 32'(m_addr));
          chk("av_writedata", 32'(ifa.av_writedata), 32'(m_wdata));
        end
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          total++; bad++;
          $display("FAIL ack_missing: actual=none required=r%0d ack at cycle %0d", e.who, e.cyc);
        end
        if (ifa.r0_ack || ifa.r1_ack) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL ack_unexpected: actual r0_ack=%0b r1_ack=%0b required=none cycle %0d",
                     ifa.r0_ack, ifa.r1_ack, cyc);
          end else begin
            e = sbq.pop_front();
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("ack_who", 32'({ifa.r1_ack, ifa.r0_ack}), 32'(e.who ? 2'b10 : 2'b01));
            chk("ack_err", 32'(e.who ? ifa.r1_err : ifa.r0_err), 32'(e.err));
            chk("rdata", 32'(e.who ? ifa.r1_rdata : ifa.r0_rdata), 32'(e.rdata));
          end
        end
      end
    end
  end

  task automatic raise(input bit who, input bit wr, input logic [15:0] a, input logic [15:0] d);
    if (who) begin ifa.r1_req = 1; ifa.r1_write = wr; ifa.r1_addr = a; ifa.r1_wdata = d; end
    else     begin ifa.r0_req = 1; ifa.r0_write = wr; ifa.r0_addr = a; ifa.r0_wdata = d; end
  endtask

  task automatic drop(input bit who);
    if (who) ifa.r1_req = 0;
    else     ifa.r0_req = 0;
  endtask

  // Waits (bounded) for the requester's ack; returns strobe-high cycles,
  // edges until ack, and the err/rdata seen with the ack.
  task automatic wait_ack(input bit who, output int sc, output int lat,
                          output bit er, output logic [15:0] rd);
    bit ok;
    sc = 0; lat = 0; er = 0; rd = 0; ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk); #1;
      lat++;
      if (ifa.av_read || ifa.av_write) sc++;
      if (who ? ifa.r1_ack : ifa.r0_ack) begin
        ok = 1;
        er = who ? ifa.r1_err : ifa.r0_err;
        rd = who ? ifa.r1_rdata : ifa.r0_rdata;
      end
    end
    chk(who ? "r1_ack_seen" : "r0_ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic xfer(input bit who, input bit wr, input logic [15:0] a, input logic [15:0] d,
                      input int w, input int dv, output int sc, output int lat,
                      output bit er, output logic [15:0] rd);
    force_w = w;
    force_d = dv;
    raise(who, wr, a, d);
    wait_ack(who, sc, lat, er, rd);
    drop(who);
    force_w = -1;
    force_d = -1;
    @(posedge clk); #1;
    chk("ack_pulse", 32'({ifa.r1_ack, ifa.r0_ack}), 32'd0);
  endtask

  task automatic requester(input bit who, input int n);
    int sc, lat; bit er; logic [15:0] rd;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      raise(who, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      wait_ack(who, sc, lat, er, rd);
      drop(who);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=no finish required=finish by 500us");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sc, lat, n;
    bit er;
    logic [15:0] rd;
    bit seq[$];
    ifa.r0_req = 0; ifa.r1_req = 0; ifa.r0_write = 0; ifa.r1_write = 0;
    ifa.r0_addr = 0; ifa.r1_addr = 0; ifa.r0_wdata = 0; ifa.r1_wdata = 0;
    ifb.r0_req = 0; ifb.r1_req = 0; ifb.r0_write = 0; ifb.r1_write = 0;
    ifb.r0_addr = 16'h0010; ifb.r1_addr = 16'h0020; ifb.r0_wdata = 0; ifb.r1_wdata = 0;
    ifb.av_waitrequest = 0; ifb.av_readdata = 16'h1234;
    #22 rst_n = 1;
    @(posedge clk); #1;
    chk("reset_busy", 32'(ifa.busy), 32'd0);
    chk("reset_strobes", 32'({ifa.av_read, ifa.av_write}), 32'd0);
    chk("reset_grant", 32'(ifa.grant), 32'd0);
    chk("reset_rdata", 32'(ifa.r0_rdata), 32'd0);

    // Round-robin contention with both requests held for four transfers.
    raise(0, 1, 16'h0200, 16'h1111);
    raise(1, 0, 16'h0300, 16'h2222);
    for (int k = 0; k < 120 && seq.size() < 4; k++) begin
      @(posedge clk); #1;
      if (ifa.r0_ack) seq.push_back(1'b0);
      if (ifa.r1_ack) seq.push_back(1'b1);
    end
    drop(0); drop(1);
    chk("rr_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) chk("rr_seq", 32'(seq[i]), 32'(i % 2));
    repeat (3) begin @(posedge clk); #1; end

    // Single write, three wait states.
    xfer(0, 1, 16'h0100, 16'h0031, 3, -1, sc, lat, er, rd);
    chk("wr_strobe_cycles", 32'(sc), 32'd4);
    chk("wr_latency", 32'(lat), 32'd5);
    chk("wr_err", 32'(er), 32'd0);
    // Zero-wait read.
    xfer(1, 0, 16'h0104, 16'h0000, 0, 16'h8001, sc, lat, er, rd);
    chk("rd_strobe_cycles", 32'(sc), 32'd1);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", 32'(rd), 32'h8001);
    // Timeout abort on a hung slave, then a normal transfer.
    xfer(0, 0, 16'h0100, 16'h0000, 30, -1, sc, lat, er, rd);
    chk("to_strobe_cycles", 32'(sc), 32'(TMO));
    chk("to_err", 32'(er), 32'd1);
    chk("to_rdata", 32'(rd), 32'(ERRV));
    xfer(0, 0, 16'h0106, 16'h0000, 2, 16'h4242, sc, lat, er, rd);
    chk("after_to_err", 32'(er), 32'd0);
    chk("after_to_rdata", 32'(rd), 32'h4242);
    // Slave accepts on the expiry edge.
    xfer(1, 0, 16'h0108, 16'h0000, TMO - 1, 16'h5A5A, sc, lat, er, rd);
    chk("bound_err", 32'(er), 32'd0);
    chk("bound_rdata", 32'(rd), 32'h5A5A);
    chk("bound_latency", 32'(lat), 32'(TMO + 1));

    // Fixed priority instance: r0 keeps winning until it drops its request.
    seq.delete();
    ifb.r0_req = 1; ifb.r1_req = 1;
    for (int k = 0; k < 100 && seq.size() < 4; k++) begin
      @(posedge clk); #1;
      if (ifb.r0_ack) seq.push_back(1'b0);
      if (ifb.r1_ack) begin
        seq.push_back(1'b1);
        chk("fp_r1_rdata", 32'(ifb.r1_rdata), 32'h1234);
      end
      if (seq.size() == 3) ifb.r0_req = 0;
    end
    ifb.r0_req = 0; ifb.r1_req = 0;
    chk("fp_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) chk("fp_seq", 32'(seq[i]), 32'(i == 3));
    // Timeout disabled: a long stall must not abort.
    repeat (2) begin @(posedge clk); #1; end
    ifb.av_waitrequest = 1;
    ifb.r0_req = 1;
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (ifb.r0_ack || ifb.r1_ack) n++; end
    chk("fp_no_timeout_acks", 32'(n), 32'd0);
    chk("fp_still_busy", 32'(ifb.busy), 32'd1);
    ifb.av_waitrequest = 0;
    n = 0;
    for (int k = 0; k < 5 && n == 0; k++) begin
      @(posedge clk); #1;
      if (ifb.r0_ack) begin
        n = 1;
        chk("fp_late_err", 32'(ifb.r0_err), 32'd0);
        chk("fp_late_rdata", 32'(ifb.r0_rdata), 32'h1234);
      end
    end
    ifb.r0_req = 0;
    chk("fp_late_ack", 32'(n), 32'd1);

    // Randomized traffic from both requesters.
    fork
      requester(0, 25);
      requester(1, 25);
    join
    repeat (4) begin @(posedge clk); #1; end

    // Reset in the middle of a stalled write.
    force_w = 6;
    raise(0, 1, 16'h0ABC, 16'h1357);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    drop(0);
    force_w = -1;
    #1;
    chk("rst_strobes", 32'({ifa.av_read, ifa.av_write}), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_ack", 32'({ifa.r1_ack, ifa.r0_ack}), 32'd0);
    chk("rst_grant", 32'(ifa.grant), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    n = 0;
    repeat (10) begin @(posedge clk); #1; if (ifa.r0_ack || ifa.r1_ack) n++; end
    chk("rst_no_ack", 32'(n), 32'd0);
    seq.delete();
    raise(0, 0, 16'h0400, 16'h0000);
    raise(1, 0, 16'h0500, 16'h0000);
    for (int k = 0; k < 40 && seq.size() == 0; k++) begin
      @(posedge clk); #1;
      if (ifa.r0_ack) seq.push_back(1'b0);
      if (ifa.r1_ack) seq.push_back(1'b1);
    end
    drop(0); drop(1);
    chk("rst_tie_count", 32'(seq.size()), 32'd1);
    if (seq.size() > 0) chk("rst_tie_winner", 32'(seq[0]), 32'd0);

    repeat (5) begin @(posedge clk); #1; end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
